// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings for the UART transmit arbiter.
// Holds the FSM state type and the byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select.
// Returns the first set req bit at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] index
);

  logic [W:0]   sum;
  logic [W-1:0] cand;

  // scan from the far end so the nearest hit to ptr wins last
  always_comb begin
    valid = 1'b0;
    index = '0;
    sum   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (W + 1)'(k);
      if (sum >= (W + 1)'(N)) begin
        sum = sum - (W + 1)'(N);
      end
      cand = sum[W-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-locked sharing of one UART TX.
// Optional watchdog compiled in with TXARB_WATCHDOG_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [BYTE_W*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ack,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     locked,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic                     err_timeout
);

  localparam int W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: NREQ must be 2..8, TIMEOUT >= 2");
  end

  state_t         state;
  logic [W-1:0]   rr_ptr;
  logic [NREQ-1:0] mask;
  logic [W-1:0]   pick_ptr;
  logic [W-1:0]   pick_idx;
  logic           pick_valid;
  logic           wd_fire;
  logic           wd_release;

  function automatic logic [W-1:0] next_id(input logic [W-1:0] i);
    return (i == W'(NREQ - 1)) ? '0 : i + W'(1);
  endfunction

  // while a frame is open only the owner may win
  always_comb begin
    mask = req;
    if (locked) begin
      mask = req & (NREQ'(1) << grant_id);
    end
  end

  assign pick_ptr = locked ? grant_id : rr_ptr;

  rr_pick #(
    .N (NREQ),
    .W (W)
  ) u_pick (
    .req   (mask),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

`ifdef TXARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          in_wait;
  logic          idle_hold;

  assign in_wait    = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign idle_hold  = (state == IDLE) && locked && !req[grant_id];
  assign wd_fire    = in_wait && (wd_cnt == CW'(TIMEOUT - 1));
  assign wd_release = idle_hold && (wd_cnt == CW'(TIMEOUT - 1));

  // watchdog: counts stalled handshakes and idle locked owners
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wd_fire;
      if (wd_fire || wd_release) begin
        wd_cnt <= '0;
      end else if (state == WAIT_DONE && !tx_busy) begin
        wd_cnt <= '0;
      end else if (in_wait || idle_hold) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign wd_release  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // arbitration FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      req_ack  <= '0;
    end else begin
      tx_start <= 1'b0;
      req_ack  <= '0;
      if (wd_fire) begin
        locked <= 1'b0;
        rr_ptr <= next_id(grant_id);
        state  <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (pick_valid) begin
              grant_id <= pick_idx;
              tx_data  <= req_data[pick_idx*BYTE_W +: BYTE_W];
              tx_start <= 1'b1;
              req_ack  <= NREQ'(1) << pick_idx;
              locked   <= ~req_last[pick_idx];
              if (req_last[pick_idx]) begin
                rr_ptr <= next_id(pick_idx);
              end
              state <= ISSUE;
            end else if (wd_release) begin
              locked <= 1'b0;
              rr_ptr <= next_id(grant_id);
            end
          end
          ISSUE: begin
            state <= WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (tx_busy) begin
              state <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (!tx_busy) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors plus multi-cycle sequences.
// Includes a small transmitter model driving tx_busy.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
`ifdef TXARB_WATCHDOG_EN
  localparam int HOLD = 12;
`else
  localparam int HOLD = 200;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic [1:0]  grant_id;
  logic        locked;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int err_pulses = 0;
  int byte_time = 5;
  bit stuck = 1'b0;
  int bcnt = 0;
  int n;
  bit ok;
  int s0;

  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic [1:0]  g;
    logic [7:0]  d;
    logic        lk;
  } vec_t;

  vec_t tbl [12];

  uart_tx_arbiter #(
    .NREQ    (N),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ack     (req_ack),
    .grant_id    (grant_id),
    .locked      (locked),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // transmitter model: busy for byte_time cycles after a start
  always @(posedge clk) begin
    if (!rst_n) bcnt <= 0;
    else if (tx_start && !stuck) bcnt <= byte_time;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  // every start must land while the transmitter is idle
  always @(posedge clk) begin
    if (rst_n && tx_start) begin
      starts++;
      checks++;
      if (tx_busy) begin
        errors++;
        $display("FAIL overlap: tx_start while tx_busy at %0t", $time);
      end
    end
    if (err_timeout) err_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_grant"}, 32'(grant_id), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_start"}, 32'(tx_start), 0);
    check({tag, "_data"}, 32'(tx_data), 0);
    check({tag, "_ack"}, 32'(req_ack), 0);
    check({tag, "_err"}, 32'(err_timeout), 0);
  endtask

  task automatic wait_start(input int bound, output int cnt, output bit seen);
    cnt  = 0;
    seen = 1'b0;
    while (cnt < bound && !seen) begin
      @(posedge clk);
      #1;
      cnt++;
      seen = tx_start;
    end
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 32'h33221100, 4'b1111, 2'd0, 8'h00, 1'b0};
    tbl[1]  = '{4'b1111, 32'h33221100, 4'b1111, 2'd1, 8'h11, 1'b0};
    tbl[2]  = '{4'b1111, 32'h33221100, 4'b1111, 2'd2, 8'h22, 1'b0};
    tbl[3]  = '{4'b1111, 32'h33221100, 4'b1111, 2'd3, 8'h33, 1'b0};
    tbl[4]  = '{4'b1111, 32'h33221100, 4'b1111, 2'd0, 8'h00, 1'b0};
    tbl[5]  = '{4'b0100, 32'h00A00000, 4'b0000, 2'd2, 8'hA0, 1'b1};
    tbl[6]  = '{4'b0111, 32'h00A111C0, 4'b0011, 2'd2, 8'hA1, 1'b1};
    tbl[7]  = '{4'b0111, 32'h00A211C0, 4'b0111, 2'd2, 8'hA2, 1'b0};
    tbl[8]  = '{4'b0011, 32'h000011C0, 4'b0011, 2'd0, 8'hC0, 1'b0};
    tbl[9]  = '{4'b0010, 32'h00005500, 4'b0010, 2'd1, 8'h55, 1'b0};
    tbl[10] = '{4'b0101, 32'h00B000C1, 4'b0101, 2'd2, 8'hB0, 1'b0};
    tbl[11] = '{4'b0001, 32'h000000C1, 4'b0001, 2'd0, 8'hC1, 1'b0};

    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    req_last = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req      = tbl[i].req;
      req_data = tbl[i].data;
      req_last = tbl[i].last;
      wait_start(40, n, ok);
      check($sformatf("v%0d_seen", i), 32'(ok), 1);
      check($sformatf("v%0d_lat", i), n, (i == 0) ? 1 : byte_time + 2);
      check($sformatf("v%0d_grant", i), 32'(grant_id), 32'(tbl[i].g));
      check($sformatf("v%0d_data", i), 32'(tx_data), 32'(tbl[i].d));
      check($sformatf("v%0d_ack", i), 32'(req_ack), 32'(4'b1 << tbl[i].g));
      check($sformatf("v%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
      @(posedge clk);
    end

    byte_time = 20;
    @(negedge clk);
    req      = 4'b0100;
    req_data = 32'h00A50000;
    req_last = 4'b0000;
    wait_start(40, n, ok);
    check("mid_seen", 32'(ok), 1);
    check("mid_grant", 32'(grant_id), 2);
    repeat (4) @(posedge clk);
    #1;
    check("mid_locked", 32'(locked), 1);
    check("mid_busy", 32'(tx_busy), 1);
    @(negedge clk);
    rst_n    = 1'b0;
    req      = 4'b1101;
    req_data = 32'hD3D2D1D0;
    req_last = 4'b1101;
    @(posedge clk);
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(5, n, ok);
    check("restart_lat", n, 1);
    check("restart_grant", 32'(grant_id), 0);
    check("restart_data", 32'(tx_data), 32'hD0);
    @(posedge clk);
    @(negedge clk);
    req = '0;

    byte_time = HOLD;
    s0 = starts;
    @(negedge clk);
    req      = 4'b0001;
    req_data = 32'h000000C5;
    req_last = 4'b0000;
    wait_start(60, n, ok);
    check("hold1_seen", 32'(ok), 1);
    check("hold1_data", 32'(tx_data), 32'hC5);
    check("hold1_locked", 32'(locked), 1);
    @(posedge clk);
    @(negedge clk);
    req_data = 32'h000000C6;
    req_last = 4'b0001;
    wait_start(HOLD + 20, n, ok);
    check("hold2_seen", 32'(ok), 1);
    check("hold2_gap", n + 1, HOLD + 3);
    check("hold2_data", 32'(tx_data), 32'hC6);
    check("hold2_locked", 32'(locked), 0);
    @(posedge clk);
    @(negedge clk);
    req = '0;
    repeat (HOLD + 20) @(posedge clk);
    #1;
    check("hold_starts", starts - s0, 2);

    byte_time = 5;
    @(negedge clk);
    req      = 4'b0100;
    req_data = 32'h00E00000;
    req_last = 4'b0000;
    wait_start(5, n, ok);
    check("own_lat", n, 1);
    check("own_locked", 32'(locked), 1);
    @(posedge clk);
    @(negedge clk);
    req      = 4'b0001;
    req_data = 32'h000000F0;
    req_last = 4'b0001;
`ifdef TXARB_WATCHDOG_EN
    wait_start(60, n, ok);
    check("release_seen", 32'(ok), 1);
    check("release_lat", n, 23);
    check("release_grant", 32'(grant_id), 0);
    check("release_data", 32'(tx_data), 32'hF0);
    check("release_locked", 32'(locked), 0);
`else
    wait_start(60, n, ok);
    check("lock_hold", 32'(ok), 0);
    @(negedge clk);
    req      = 4'b0101;
    req_data = 32'h00E100F0;
    req_last = 4'b0101;
    wait_start(10, n, ok);
    check("own_end_lat", n, 1);
    check("own_end_grant", 32'(grant_id), 2);
    check("own_end_data", 32'(tx_data), 32'hE1);
    @(posedge clk);
    @(negedge clk);
    req = 4'b0001;
    wait_start(20, n, ok);
    check("after_own_grant", 32'(grant_id), 0);
    check("after_own_data", 32'(tx_data), 32'hF0);
`endif
    @(posedge clk);
    @(negedge clk);
    req = '0;
    repeat (10) @(posedge clk);

`ifdef TXARB_WATCHDOG_EN
    stuck = 1'b1;
    @(negedge clk);
    req      = 4'b0010;
    req_data = 32'h00007700;
    req_last = 4'b0000;
    wait_start(5, n, ok);
    check("wd_grant", 32'(grant_id), 1);
    @(posedge clk);
    @(negedge clk);
    req = '0;
    repeat (15) @(posedge clk);
    #1;
    check("wd_early", 32'(err_timeout), 0);
    @(posedge clk);
    #1;
    check("wd_pulse", 32'(err_timeout), 1);
    check("wd_locked", 32'(locked), 0);
    @(negedge clk);
    req      = 4'b0011;
    req_data = 32'h00000088;
    req_last = 4'b0011;
    @(posedge clk);
    #1;
    check("wd_idle", 32'(tx_start), 1);
    check("wd_rr", 32'(grant_id), 0);
    check("wd_one", 32'(err_timeout), 0);
    @(negedge clk);
    req = '0;
    repeat (25) @(posedge clk);
    stuck = 1'b0;
    #1;
    check("err_pulses", err_pulses, 2);
`else
    #1;
    check("err_pulses", err_pulses, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
